// File: rtl/mux_scanner.sv
// mux_scanner: time-multiplexed one-hot channel scanner for display strobing.
// Walks a select across CHANNELS outputs and dwells TIMING_SCALE clk_in cycles
// on each unmasked channel. Emits slot (tick) and frame strobes.
// Optional feature macro: MUX_SCANNER_BLANK_EN inserts BLANK_CYCLES of
// all-inactive select between slots.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | not scanning (disabled, all masked or after reset); select inactive
//   ACTIVE | driving the channel in idx_out; slot timer running
//   BLANK  | (macro only) anti-ghosting gap after an advance; select inactive
module mux_scanner #(
    parameter int TIMING_SCALE = 24,
    parameter int CHANNELS     = 6,
    parameter int BLANK_CYCLES = 2,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        en_in,
    input  logic                        dir_in,
    input  logic [CHANNELS-1:0]         skip_mask_in,
    output logic [CHANNELS-1:0]         sel_out,
    output logic [$clog2(CHANNELS)-1:0] idx_out,
    output logic                        tick_out,
    output logic                        frame_out
);

    localparam int IDX_W   = $clog2(CHANNELS);
    localparam int CNT_MAX = (TIMING_SCALE > BLANK_CYCLES) ? TIMING_SCALE : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(TIMING_SCALE - 1);
`ifdef MUX_SCANNER_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
`endif
    // XOR mask that turns a positive one-hot into the output polarity
    localparam logic [CHANNELS-1:0] SEL_IDLE = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : '0;

`ifdef MUX_SCANNER_BLANK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_BLANK} state_t;
`else
    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
`endif

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHANNELS-1:0]  sel_q, sel_d;
    logic                 tick_q, tick_d;
    logic                 frame_q, frame_d;

    logic [CHANNELS-1:0]  sel_raw;
    logic [IDX_W-1:0]     nxt;
    logic                 all_masked;

    // First unmasked channel walking from start in the given direction.
    // Exclusive search wraps all the way round so a lone channel finds itself.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] start,
                                                  input logic dn,
                                                  input logic [CHANNELS-1:0] mask,
                                                  input logic incl);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] ci;
        logic             found;
        int               cand;
        res   = start;
        found = 1'b0;
        for (int k = 0; k <= CHANNELS; k++) begin
            if (dn)
                cand = (int'(start) + CHANNELS - (k % CHANNELS)) % CHANNELS;
            else
                cand = (int'(start) + k) % CHANNELS;
            ci = cand[IDX_W-1:0];
            if (!found && (k != 0 || incl) && !mask[ci]) begin
                res   = ci;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [CHANNELS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [CHANNELS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Next-state, slot timer and registered-output computation
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        sel_raw    = '0;
        tick_d     = 1'b0;
        frame_d    = 1'b0;
        nxt        = '0;
        all_masked = &skip_mask_in;
        case (state_q)
            ST_IDLE: begin
                if (en_in && !all_masked) begin
                    nxt     = next_idx(idx_q, dir_in, skip_mask_in, 1'b1);
                    idx_d   = nxt;
                    cnt_d   = SLOT_LOAD;
                    sel_raw = onehot(nxt);
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!en_in || all_masked) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    nxt     = next_idx(idx_q, dir_in, skip_mask_in, 1'b0);
                    idx_d   = nxt;
                    tick_d  = 1'b1;
                    frame_d = dir_in ? (nxt >= idx_q) : (nxt <= idx_q);
`ifdef MUX_SCANNER_BLANK_EN
                    cnt_d   = BLANK_LOAD;
                    state_d = ST_BLANK;
`else
                    cnt_d   = SLOT_LOAD;
                    sel_raw = onehot(nxt);
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (!skip_mask_in[idx_q])
                        sel_raw = onehot(idx_q);
                end
            end
`ifdef MUX_SCANNER_BLANK_EN
            ST_BLANK: begin
                if (!en_in || all_masked) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d   = SLOT_LOAD;
                    state_d = ST_ACTIVE;
                    if (!skip_mask_in[idx_q])
                        sel_raw = onehot(idx_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        sel_d = sel_raw ^ SEL_IDLE;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= SEL_IDLE;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign sel_out   = sel_q;
    assign idx_out   = idx_q;
    assign tick_out  = tick_q;
    assign frame_out = frame_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Scoreboard bench for mux_scanner: stimulus pushes predicted outputs, a
// monitor pops and compares them one cycle later. Honours MUX_SCANNER_BLANK_EN.
module tb_mux_scanner;

    localparam int TS = 4;
    localparam int CH = 5;
    localparam int BC = 2;
    localparam int AL = 0;
    localparam int IW = $clog2(CH);
`ifdef MUX_SCANNER_BLANK_EN
    localparam int B = BC;
`else
    localparam int B = 0;
`endif
    localparam logic [CH-1:0] INACT = (AL != 0) ? {CH{1'b1}} : '0;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          en_in  = 1'b0;
    logic          dir_in = 1'b0;
    logic [CH-1:0] skip_mask_in = '0;
    logic [CH-1:0] sel_out;
    logic [IW-1:0] idx_out;
    logic          tick_out;
    logic          frame_out;

    mux_scanner #(
        .TIMING_SCALE(TS),
        .CHANNELS    (CH),
        .BLANK_CYCLES(BC),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_in       (en_in),
        .dir_in      (dir_in),
        .skip_mask_in(skip_mask_in),
        .sel_out     (sel_out),
        .idx_out     (idx_out),
        .tick_out    (tick_out),
        .frame_out   (frame_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [CH-1:0] sel;
        int            idx;
        bit            tick;
        bit            frame;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_ticks = 0;
    int   n_frames = 0;

    // Reference model: current channel, whether scanning, and the age of the
    // current channel in cycles. Ages 0..B-1 are the blank gap before it is
    // shown, ages B..B+TS-1 are its visible slot.
    bit m_on  = 1'b0;
    int m_idx = 0;
    int m_age = 0;

    function automatic bit is_masked(input logic [CH-1:0] m, input int c);
        return |(m & (CH'(1) << c));
    endfunction

    // Walk offsets first_off..CH from 'from'; off returns the distance travelled
    function automatic int seek(input int from, input bit dn, input logic [CH-1:0] m,
                                input int first_off, output int off);
        for (int j = first_off; j <= CH; j++) begin
            int c;
            c = dn ? (((from - j) % CH) + CH) % CH : (from + j) % CH;
            if (!is_masked(m, c)) begin
                off = j;
                return c;
            end
        end
        off = 0;
        return from;
    endfunction

    task automatic model(input bit rst, input bit en, input bit dn,
                         input logic [CH-1:0] m, output exp_t e);
        int off;
        int nidx;
        e.tick  = 1'b0;
        e.frame = 1'b0;
        if (rst) begin
            m_on  = 1'b0;
            m_idx = 0;
            m_age = 0;
        end else if (!en || m == {CH{1'b1}}) begin
            m_on  = 1'b0;
            m_age = 0;
        end else if (!m_on) begin
            m_idx = seek(m_idx, dn, m, 0, off);
            m_on  = 1'b1;
            m_age = B;
        end else if (m_age == B + TS - 1) begin
            nidx    = seek(m_idx, dn, m, 1, off);
            e.tick  = 1'b1;
            e.frame = dn ? (m_idx - off < 0) : (m_idx + off >= CH);
            m_idx   = nidx;
            m_age   = 0;
        end else begin
            m_age++;
        end
        e.idx = m_idx;
        e.sel = (m_on && m_age >= B && !is_masked(m, m_idx))
                ? ((CH'(1) << m_idx) ^ INACT) : INACT;
    endtask

    bit            c_rst = 1'b1;
    bit            c_en  = 1'b0;
    bit            c_dir = 1'b0;
    logic [CH-1:0] c_mask = '0;

    // Drive one cycle of inputs and push the outputs expected after the next edge
    task automatic cyc();
        exp_t e;
        @(negedge clk_in);
        rst_in       = c_rst;
        en_in        = c_en;
        dir_in       = c_dir;
        skip_mask_in = c_mask;
        model(c_rst, c_en, c_dir, c_mask, e);
        sb_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest prediction each cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sel_out",   32'(sel_out),   32'(e.sel));
                chk("idx_out",   32'(idx_out),   32'(e.idx));
                chk("tick_out",  32'(tick_out),  32'(e.tick));
                chk("frame_out", 32'(frame_out), 32'(e.frame));
                if (e.tick)  n_ticks++;
                if (e.frame) n_frames++;
            end
        end
    end

    initial begin
        // Reset, then ascending scan with nothing masked
        c_rst = 1'b1; c_en = 1'b0; c_dir = 1'b0; c_mask = '0;
        run(3);
        c_rst = 1'b0; c_en = 1'b1;
        run(3 * CH * (TS + B));

        // Drop enable mid-slot at index 2, then resume there
        for (int k = 0; k < 100 && !(m_on && m_idx == 2 && m_age == B + 1); k++) cyc();
        c_en = 1'b0;
        run(3);
        c_en = 1'b1;
        run(2 * (TS + B) + 2);

        // Mask the active channel 1 mid-slot; the advance still lands on 2
        for (int k = 0; k < 100 && !(m_on && m_idx == 1 && m_age == B + 1); k++) cyc();
        c_mask = CH'(1) << 1;
        run(2 * (TS + B));
        c_mask = '0;

        // Descending with channel 2 skipped, starting from a fresh reset
        c_rst = 1'b1;
        run(1);
        c_rst = 1'b0; c_dir = 1'b1; c_mask = CH'(4);
        run(3 * CH * (TS + B));

        // All channels masked, then released
        c_mask = '1;
        run(10);
        c_mask = '0; c_dir = 1'b0;
        run(TS + B + 3);

        // Single unmasked channel: every advance is a frame
        c_mask = ~(CH'(1) << 3);
        run(3 * (TS + B));
        c_mask = '0;

        // Reset during an active slot, then during a blank gap if present
        for (int k = 0; k < 100 && !(m_on && m_age == B + 2); k++) cyc();
        c_rst = 1'b1; run(1); c_rst = 1'b0;
        run(2 * (TS + B));
        if (B > 0) begin
            for (int k = 0; k < 100 && !(m_on && m_age == 0); k++) cyc();
            c_rst = 1'b1; run(1); c_rst = 1'b0;
            run(2 * (TS + B));
        end

        // Randomised operation
        for (int k = 0; k < 3000; k++) begin
            c_rst = ($urandom_range(0, 149) == 0);
            if (c_en) begin
                if ($urandom_range(0, 59) == 0) c_en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                c_en = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) c_dir = ~c_dir;
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 4))
                    0:       c_mask = '0;
                    1:       c_mask = '1;
                    2:       c_mask = CH'(1) << m_idx;
                    3:       c_mask = ~(CH'(1) << $urandom_range(0, CH - 1));
                    default: c_mask = CH'($urandom) & CH'($urandom);
                endcase
            end
            cyc();
        end

        c_rst = 1'b0; c_en = 1'b0;
        run(2);
        @(posedge clk_in);
        #3;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        checks++;
        if (n_ticks == 0 || n_frames == 0) begin
            errors++;
            $display("FAIL strobe_activity: ticks %0d frames %0d, both required nonzero", n_ticks, n_frames);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scanner.md
# mux_scanner

Parametrised time-multiplexing channel scanner: divides `clk_in` by a programmable slot length and walks a one-hot select across `CHANNELS` outputs, for digit/segment strobing of LED and 7-segment displays. Generalises the fixed one-hot mux counter with:

- channel count, up/down direction and per-channel skip masking;
- enable control and output polarity selection;
- slot and frame strobes;
- an optional anti-ghosting blanking interval.

It sits between the system clock and the display drive logic; the data path uses `idx_out` to pick the value for the active channel.

## Interface
- `TIMING_SCALE`, 24: `clk_in` cycles per active slot; must be ≥ 2.
- `CHANNELS`, 6: number of select outputs; must be ≥ 2.
- `BLANK_CYCLES`, 2: blanking cycles between slots when the blanking macro is defined; must be ≥ 1.
- `ACTIVE_LOW`, 0: when 1, `sel_out` is inverted (asserted channel = 0, inactive = 1).

- `clk_in`  input  1  sole clock; all logic on the rising edge.
- `rst_in`  input  1  reset; synchronous, active-high.
- `en_in`  input  1  scan enable.
- `dir_in`  input  1  0 = ascending index, 1 = descending index; sampled at each advance.
- `skip_mask_in`  input  CHANNELS  bit i = 1 excludes channel i from the scan.
- `sel_out`  output  CHANNELS  one-hot channel select, registered, polarity per `ACTIVE_LOW`.
- `idx_out`  output  $clog2(CHANNELS)  current channel index, registered.
- `tick_out`  output  1  one-cycle pulse on each slot advance.
- `frame_out`  output  1  one-cycle pulse when the advance wraps the scan.

## Operation
- **States:** IDLE, ACTIVE, BLANK (BLANK exists only with the blanking macro).
- **Reset** (`rst_in` = 1 at an edge; overrides everything, including mid-slot and mid-blank):
  - state IDLE; prescaler 0; `idx_out` 0; `tick_out` 0; `frame_out` 0;
  - `sel_out` inactive (all 0, or all 1 if `ACTIVE_LOW`).
- **IDLE → ACTIVE:** when `en_in` = 1 and at least one channel is unmasked.
  - `idx_out` is loaded with the first unmasked channel, searching from the current index inclusive in `dir_in` order.
  - Prescaler is cleared to 0.
- **ACTIVE:**
  - `sel_out` asserts bit `idx_out`; the prescaler increments each cycle.
  - At terminal count (`TIMING_SCALE-1`), the advance happens:
    - `idx_out` ← next unmasked channel in `dir_in` order, modulo `CHANNELS`;
    - prescaler ← 0; `tick_out` = 1.
  - `frame_out` = 1 on an advance when:
    - ascending: new index ≤ old index;
    - descending: new index ≥ old index.
  - With a single unmasked channel, every advance is therefore a frame.
- **Mask change:**
  - If the channel in `idx_out` becomes masked mid-slot, `sel_out` goes inactive on the next cycle while the slot timing continues unchanged.
  - The next advance skips that channel.
- **All channels masked:** go to IDLE, `sel_out` inactive, `idx_out` held, no strobes.
- **`en_in` = 0:** next cycle state IDLE, `sel_out` inactive, prescaler 0, `idx_out` held. Re-enabling resumes from the held index.
- **Index arithmetic:** modulo `CHANNELS`, which need not be a power of two. Indices ≥ `CHANNELS` never appear on `idx_out`.

## Timing
- All outputs are registered.
- `sel_out` reflects an `en_in` rise on the first edge after it is sampled high: 1 cycle latency.
- Slot length:
  - `TIMING_SCALE` cycles without blanking;
  - `TIMING_SCALE + BLANK_CYCLES` cycles with blanking.
- Frame period (all unmasked) = `CHANNELS` × slot length.
- `tick_out` and `frame_out` assert in the same cycle as the new `idx_out`, for exactly 1 cycle.
- `en_in` falling on the terminal-count cycle: disable wins; no advance, no strobe.

## Configuration
- Macro: `MUX_SCANNER_BLANK_EN`.
- **Defined:**
  - On advance, the block enters BLANK. `idx_out`, `tick_out` and `frame_out` update on BLANK entry.
  - `sel_out` stays inactive for `BLANK_CYCLES` cycles, then ACTIVE drives the new channel with the prescaler at 0.
  - `en_in` = 0 or reset during BLANK → IDLE.
- **Undefined:**
  - BLANK does not exist and `BLANK_CYCLES` is ignored.
  - `sel_out` switches directly from old to new channel on the advance edge.

## Test plan
- **Reset and ascending scan.** TIMING_SCALE=4, CHANNELS=4, macro off; reset, then `en_in`=1, `dir_in`=0, mask 0.
  - `sel_out` = 0001 for 4 cycles, then 0010, 0100, 1000, 0001.
  - `tick_out` every 4 cycles; `frame_out` only on the 1000→0001 advance (every 16 cycles).
- **Descending with skip and non-power-of-two count.** CHANNELS=5, `dir_in`=1, mask 00100.
  - Index sequence 0,4,3,1,0.
  - `frame_out` on the 0→4 advance only.
- **Blanking.** Macro on, BLANK_CYCLES=2, TIMING_SCALE=4.
  - `sel_out` active 4 cycles, all-inactive 2 cycles, next channel active.
  - `tick_out` coincides with the first blank cycle.
  - `ACTIVE_LOW`=1: inactive reads all 1s.
- **Enable and masking boundaries.**
  - `en_in` dropped mid-slot at index 2 → inactive next cycle, index held at 2; re-enable → channel 2 with a full 4-cycle slot.
  - Mask set to all 1s → no ticks, `sel_out` inactive.
- **Mask change mid-slot.** Mask the active channel 1 mid-slot.
  - `sel_out` inactive next cycle.
  - Advance still occurs on schedule, to index 2.
- **Mid-operation reset.** `rst_in` pulsed during ACTIVE and (macro on) during BLANK.
  - Next cycle: index 0, outputs inactive, strobes 0.
  - Scan restarts at channel 0 with a full slot.
